// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and AXI constants for the line-refill read arbiter
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int          LINE_WORDS_DEF = 8;
   localparam logic        OWNER_I        = 1'b0;
   localparam logic        OWNER_D        = 1'b1;
   localparam logic [1:0]  BURST_INCR     = 2'b01;
   localparam logic [2:0]  SIZE_4B        = 3'b010;
   localparam logic [1:0]  RESP_OKAY      = 2'b00;
   localparam logic [3:0]  ID_I_DEF       = 4'd0;
   localparam logic [3:0]  ID_D_DEF       = 4'd1;

   function automatic logic [26:0] line_tag(input logic [31:0] addr);
      return addr[31:5];
   endfunction

endpackage

// File: rtl/line_rd_buffer.sv
// rtl/line_rd_buffer.sv - R-beat capture: saturating beat index, line storage, sticky error
module line_rd_buffer
   import axi_arb_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        beat_en,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   output logic [31:0] line_data [LINE_WORDS],
   output logic        err
);

   localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [BW-1:0] BEAT_MAX = BW'(LINE_WORDS - 1);

   logic [BW-1:0] beat_q, beat_d;
   logic          err_q, err_d;
   logic [31:0]   line_q [LINE_WORDS];
   logic [31:0]   line_d [LINE_WORDS];

   // start only rewinds the index; stored words survive until overwritten by new beats
   always_comb begin
      line_d = line_q;
      beat_d = beat_q;
      err_d  = err_q;
      if (start) begin
         beat_d = '0;
         err_d  = 1'b0;
      end else if (beat_en) begin
         line_d[beat_q] = rdata;
         if (beat_q != BEAT_MAX) begin
            beat_d = beat_q + BW'(1);
         end
         err_d = err_q | (rresp != RESP_OKAY);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_q <= '0;
         err_q  <= 1'b0;
         for (int k = 0; k < LINE_WORDS; k++) begin
            line_q[k] <= '0;
         end
      end else begin
         beat_q <= beat_d;
         err_q  <= err_d;
         line_q <= line_d;
      end
   end

   assign line_data = line_q;
   assign err       = err_q;

endmodule

// File: rtl/axi_line_rd_arbiter.sv
// rtl/axi_line_rd_arbiter.sv - icache/dcache line refills over one AXI4 read channel
// ARB_RR_EN selects round-robin arbitration; default is fixed dcache-first priority.
module axi_line_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int         LINE_WORDS = LINE_WORDS_DEF,
   parameter logic [3:0] ID_I       = ID_I_DEF,
   parameter logic [3:0] ID_D       = ID_D_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_gnt,
   output logic [31:0] line_data [LINE_WORDS],
   output logic        rd_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic [26:0] tag_q, tag_d;
   logic        win;
   logic        start;
   logic        buf_err;
   logic        unused_ok;

   assign unused_ok = ^{rid, i_addr[4:0], d_addr[4:0]};

`ifdef ARB_RR_EN
   logic ptr_q, ptr_d;

   // ptr_q names the requester that wins the next tie
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == DONE) begin
         ptr_d = ~owner_q;
      end
      if (i_req && d_req) begin
         win = ptr_q;
      end else begin
         win = d_req ? OWNER_D : OWNER_I;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= OWNER_I;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      win = d_req ? OWNER_D : OWNER_I;
   end
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      tag_d   = tag_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               owner_d = win;
               tag_d   = (win == OWNER_D) ? line_tag(d_addr) : line_tag(i_addr);
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (arready) begin
               start   = 1'b1;
               state_d = DATA;
            end
         end
         DATA: begin
            if (rvalid && rlast) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= OWNER_I;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         tag_q   <= tag_d;
      end
   end

   line_rd_buffer #(
      .LINE_WORDS (LINE_WORDS)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .beat_en   (rvalid && rready),
      .rdata     (rdata),
      .rresp     (rresp),
      .line_data (line_data),
      .err       (buf_err)
   );

   assign arvalid = (state_q == ADDR);
   assign rready  = (state_q == DATA);
   assign araddr  = {tag_q, 5'b0};
   assign arid    = (owner_q == OWNER_D) ? ID_D : ID_I;
   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = SIZE_4B;
   assign arburst = BURST_INCR;
   assign i_gnt   = (state_q == DONE) && (owner_q == OWNER_I);
   assign d_gnt   = (state_q == DONE) && (owner_q == OWNER_D);
   assign rd_err  = (state_q == DONE) && buf_err;

endmodule

// File: doc/axi_line_rd_arbiter.md
Name: axi_line_rd_arbiter

Overview:
Shares the single AXI4 read channel between the instruction cache and data cache line-refill ports. Accepts one 8-word line request at a time, issues an INCR burst on AR, and collects R beats into a line buffer. Returns a one-cycle grant to the winning cache, with the full line stable on the shared line-data bus. Sits between icache/dcache and the top-level AXI interface.

Parameters:
LINE_WORDS, 8, words per refill line; fixes arlen = LINE_WORDS-1.
ID_I, 4'd0, arid used for icache bursts.
ID_D, 4'd1, arid used for dcache bursts.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  icache refill request, held until i_gnt
i_addr  in  32  icache line address, bits [4:0] ignored
i_gnt  out  1  one-cycle pulse: icache line ready on line_data
d_req  in  1  dcache refill request, held until d_gnt
d_addr  in  32  dcache line address, bits [4:0] ignored
d_gnt  out  1  one-cycle pulse: dcache line ready on line_data
line_data  out  32 x LINE_WORDS  unpacked line buffer, word k = address base+4k
rd_err  out  1  high with gnt if any beat of the burst had rresp != OKAY
arid  out  4  burst ID
araddr  out  32  {addr[31:5],5'b0}
arlen  out  8  LINE_WORDS-1
arsize  out  3  3'b010
arburst  out  2  2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored except in ARB_RR_EN debug checks (none required)
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (rst low, asynchronous): state IDLE; arvalid=0, rready=0, i_gnt=d_gnt=0, rd_err=0, line_data all 0, beat counter 0, priority pointer = icache.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if any req, select the winner and latch its address and owner; next state ADDR. Without ARB_RR_EN, dcache has fixed priority over icache. No req: stay.
- ADDR: arvalid=1 with latched araddr/arid. Stays until arvalid&&arready; then go to DATA with beat=0. AR fields stay stable while waiting.
- DATA: rready=1. Each rvalid beat writes rdata to line_data[beat], beat++, and ORs (rresp!=0) into the error flag. The beat index saturates at LINE_WORDS-1; extra beats overwrite the last word. A beat with rlast ends the burst (next DONE) even if fewer than LINE_WORDS beats arrived; missing words keep their old values.
- DONE: pulse i_gnt or d_gnt (owner only) for exactly 1 cycle, with rd_err valid; then IDLE.
- line_data holds its value from DONE until the first R beat of the next burst. The requester may register it in the gnt cycle or any later cycle before the next grant.
- Requesters must drop req in the cycle after gnt. IDLE re-samples req in that cycle, so a held req causes a second refill (legal, wasteful).
- Latency with arready and rvalid always 1: req in cycle 0 → arvalid in cycle 1 → beats in cycles 2..9 → gnt in cycle 10.
- Simultaneous i_req and d_req in IDLE: one winner per the arbitration policy; the loser waits in place with no timeout.
- Address changes while waiting are ignored; the address is latched in IDLE.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. The 1-bit pointer flips to the other requester after each DONE; on a tie, the requester not served last wins. Reset pointer favours icache.
- Undefined: fixed dcache-first priority; no pointer register.

Decomposition:
- Package axi_arb_pkg: state enum (IDLE/ADDR/DATA/DONE), LINE_WORDS, OWNER_I/OWNER_D owner encoding, AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY), ID_I/ID_D defaults.
- One natural sub-module, line_rd_buffer: beat counter, line_data storage and error accumulation. Inputs: rvalid&&rready, rdata, rresp, start. All arbitration and the FSM stay in the top module.

Test Plan:
- Single icache miss, i_addr=0x1FC0_0024, arready=rvalid=1, rdata=0x100+k: araddr=0x1FC0_0020, arlen=7, arid=0; i_gnt in cycle 10; line_data[k]=0x100+k; rd_err=0.
- Simultaneous i_req/d_req in the same cycle: fixed mode serves dcache then icache. ARB_RR_EN: first tie → icache, second tie → dcache; each gnt pulses exactly once.
- Back-pressure: arready low 5 cycles, then rvalid toggling 1/0: AR fields stable while arvalid&&!arready; 8 words captured correctly; gnt only after rlast.
- rresp=SLVERR on beat 3 only: gnt asserted with rd_err=1; the next clean burst gives rd_err=0.
- Early rlast on beat 4: DONE after 4 beats; line_data[4..7] keep the previous burst's values.
- rst driven low mid-DATA (beat 5), then released: arvalid/rready/gnt drop to 0 without waiting for a clock edge; FSM in IDLE; a new request completes normally.
